// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Sequences an iCE40 PLL from the reference-clock side. It pulses the PLL
// RESETB pin, waits for LOCK to be stable, and retries a bounded number of
// times before giving up. It also offers a bypass path. The downstream PLL
// clock domain stays in reset until lock has been proven.
// Everything runs on the reference clock.
//
// Parameters
//   RESET_HOLD   : cycles pll_resetb is held low per (re)start      (>= 1)
//   LOCK_STABLE  : consecutive synchronized lock-high cycles needed (>= 1)
//   LOCK_TIMEOUT : cycles allowed per lock attempt (> LOCK_STABLE)
//   MAX_RETRIES  : timeouts tolerated before FAIL                   (>= 1)
//
// Ports
//   clk         in  reference clock (also the PLL REFERENCECLK)
//   reset       in  asynchronous active-low reset
//   bypass_req  in  synchronous request to bypass the PLL
//   lock        in  PLL LOCK, asynchronous to clk
//   pll_resetb  out PLL RESETB (active-low)
//   pll_bypass  out PLL BYPASS
//   rst_out_n   out active-low reset for the PLL output clock domain
//   locked      out high only while running on a proven lock
//   fail        out high only after the retry budget is exhausted
//   retry_count out timeouts since the last RUN entry or BYPASS exit
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int RESET_HOLD   = 4,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 64,
  parameter int MAX_RETRIES  = 3,
  localparam int RW = $clog2(MAX_RETRIES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bypass_req,
  input  logic          lock,
  output logic          pll_resetb,
  output logic          pll_bypass,
  output logic          rst_out_n,
  output logic          locked,
  output logic          fail,
  output logic [RW-1:0] retry_count
);

  localparam int MAX_AB  = (RESET_HOLD > LOCK_STABLE) ? RESET_HOLD : LOCK_STABLE;
  localparam int CNT_MAX = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_C    = CW'(RESET_HOLD);
  localparam logic [CW-1:0] STABLE_C  = CW'(LOCK_STABLE);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(LOCK_TIMEOUT);
  localparam logic [RW-1:0] RETRY_C   = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL,
    ST_BYPASS
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] hold_cnt_reg, hold_cnt_next;
  logic [CW-1:0] stable_cnt_reg, stable_cnt_next;
  logic [CW-1:0] timeout_cnt_reg, timeout_cnt_next;
  logic [RW-1:0] retry_reg, retry_next;
  logic          lock_meta_reg, lock_s_reg;

  logic [CW-1:0] hold_inc, stable_inc, timeout_inc;
  logic [RW-1:0] retry_inc;
  logic          retry_exhausted;

  logic pll_resetb_next, pll_bypass_next, rst_out_n_next, locked_next, fail_next;

  // Saturating increments: counters park at their terminal value, never wrap.
  assign hold_inc        = (hold_cnt_reg    >= HOLD_C)    ? hold_cnt_reg    : hold_cnt_reg    + CW'(1);
  assign stable_inc      = (stable_cnt_reg  >= STABLE_C)  ? stable_cnt_reg  : stable_cnt_reg  + CW'(1);
  assign timeout_inc     = (timeout_cnt_reg >= TIMEOUT_C) ? timeout_cnt_reg : timeout_cnt_reg + CW'(1);
  assign retry_inc       = (retry_reg       >= RETRY_C)   ? retry_reg       : retry_reg       + RW'(1);
  assign retry_exhausted = (retry_inc >= RETRY_C);

  assign retry_count = retry_reg;

  always_comb begin
    state_next       = state_reg;
    hold_cnt_next    = hold_cnt_reg;
    stable_cnt_next  = stable_cnt_reg;
    timeout_cnt_next = timeout_cnt_reg;
    retry_next       = retry_reg;

    if (bypass_req) begin
      // Bypass overrides every other transition, including leaving FAIL.
      state_next = ST_BYPASS;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (hold_inc >= HOLD_C) begin
            state_next       = ST_WAIT_LOCK;
            hold_cnt_next    = '0;
            stable_cnt_next  = '0;
            timeout_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_inc;
          end
        end

        ST_WAIT_LOCK: begin
          timeout_cnt_next = timeout_inc;
          if (lock_s_reg) begin
            stable_cnt_next = CW'(1);
            if (STABLE_C <= CW'(1)) begin
              state_next = ST_RUN;
              retry_next = '0;
            end else begin
              state_next = ST_STABLE;
            end
          end else if (timeout_inc >= TIMEOUT_C) begin
            retry_next    = retry_inc;
            hold_cnt_next = '0;
            state_next    = retry_exhausted ? ST_FAIL : ST_HOLD;
          end
        end

        // The timeout counter keeps running through STABLE and is never
        // cleared by a lock drop. The deadline bounds the whole attempt, so
        // a lock that keeps bouncing cannot postpone the retry forever.
        ST_STABLE: begin
          timeout_cnt_next = timeout_inc;
          if (lock_s_reg && (stable_inc >= STABLE_C)) begin
            state_next = ST_RUN;
            retry_next = '0;
          end else if (timeout_inc >= TIMEOUT_C) begin
            retry_next    = retry_inc;
            hold_cnt_next = '0;
            state_next    = retry_exhausted ? ST_FAIL : ST_HOLD;
          end else if (!lock_s_reg) begin
            state_next      = ST_WAIT_LOCK;
            stable_cnt_next = '0;
          end else begin
            stable_cnt_next = stable_inc;
          end
        end

        // A lock loss while running restarts the PLL without spending retries.
        ST_RUN: begin
          if (!lock_s_reg) begin
            state_next    = ST_HOLD;
            hold_cnt_next = '0;
          end
        end

        ST_FAIL: begin
          state_next = ST_FAIL;
        end

        ST_BYPASS: begin
          state_next       = ST_HOLD;
          hold_cnt_next    = '0;
          stable_cnt_next  = '0;
          timeout_cnt_next = '0;
          retry_next       = '0;
        end

        default: begin
          state_next = ST_HOLD;
        end
      endcase
    end

    // Outputs are decoded from the next state so they move on the same edge
    // as the transition.
    pll_resetb_next = (state_next == ST_WAIT_LOCK) || (state_next == ST_STABLE) ||
                      (state_next == ST_RUN);
    pll_bypass_next = (state_next == ST_BYPASS);
    rst_out_n_next  = (state_next == ST_RUN) || (state_next == ST_BYPASS);
    locked_next     = (state_next == ST_RUN);
    fail_next       = (state_next == ST_FAIL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_meta_reg   <= 1'b0;
      lock_s_reg      <= 1'b0;
      state_reg       <= ST_HOLD;
      hold_cnt_reg    <= '0;
      stable_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
      retry_reg       <= '0;
      pll_resetb      <= 1'b0;
      pll_bypass      <= 1'b0;
      rst_out_n       <= 1'b0;
      locked          <= 1'b0;
      fail            <= 1'b0;
    end else begin
      // Two-flop synchronizer; the FSM only ever looks at lock_s_reg.
      lock_meta_reg   <= lock;
      lock_s_reg      <= lock_meta_reg;
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      stable_cnt_reg  <= stable_cnt_next;
      timeout_cnt_reg <= timeout_cnt_next;
      retry_reg       <= retry_next;
      pll_resetb      <= pll_resetb_next;
      pll_bypass      <= pll_bypass_next;
      rst_out_n       <= rst_out_n_next;
      locked          <= locked_next;
      fail            <= fail_next;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Directed scenarios plus a randomized run for pll_lock_sequencer with
// default parameters. A behavioural model describes each lock attempt by
// elapsed time and consecutive-lock run length. It supplies the expected
// outputs every cycle. Each scenario also checks the key edge numbers
// as constants.
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  localparam int RESET_HOLD   = 4;
  localparam int LOCK_STABLE  = 16;
  localparam int LOCK_TIMEOUT = 64;
  localparam int MAX_RETRIES  = 3;
  localparam int RW           = 2;

  logic          clk        = 1'b0;
  logic          reset      = 1'b0;
  logic          bypass_req = 1'b0;
  logic          lock       = 1'b0;
  logic          pll_resetb, pll_bypass, rst_out_n, locked, fail;
  logic [RW-1:0] retry_count;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RESET_HOLD  (RESET_HOLD),
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RETRIES (MAX_RETRIES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bypass_req (bypass_req),
    .lock       (lock),
    .pll_resetb (pll_resetb),
    .pll_bypass (pll_bypass),
    .rst_out_n  (rst_out_n),
    .locked     (locked),
    .fail       (fail),
    .retry_count(retry_count)
  );

  logic [6:0] dut_out;
  assign dut_out = {pll_resetb, pll_bypass, rst_out_n, locked, fail, retry_count};

  // ------------------------------------------------------------------------
  // Reference model: phase + time stamps. An attempt ends in RUN once the
  // delayed lock has been high LOCK_STABLE edges in a row. It ends in a
  // timeout once LOCK_TIMEOUT edges have elapsed, except on the edge where
  // a waiting attempt first sees lock.
  // ------------------------------------------------------------------------
  localparam int P_HOLD = 0, P_TRY = 1, P_RUN = 2, P_FAIL = 3, P_BYP = 4;

  int         m_phase, m_t, m_run, m_retries;
  logic       m_d0, m_d1;
  logic [6:0] exp_out;

  task automatic model_outputs();
    exp_out = {(m_phase == P_TRY) || (m_phase == P_RUN),
               (m_phase == P_BYP),
               (m_phase == P_RUN) || (m_phase == P_BYP),
               (m_phase == P_RUN),
               (m_phase == P_FAIL),
               RW'(m_retries)};
  endtask

  task automatic model_reset();
    m_phase = P_HOLD; m_t = 0; m_run = 0; m_retries = 0;
    m_d0 = 1'b0; m_d1 = 1'b0;
    model_outputs();
  endtask

  task automatic model_step();
    logic ls;
    bit   waiting;
    ls   = m_d1;        // lock as sampled two edges ago
    m_d1 = m_d0;
    m_d0 = lock;
    if (bypass_req) begin
      m_phase = P_BYP;
    end else begin
      case (m_phase)
        P_HOLD: begin
          m_t++;
          if (m_t == RESET_HOLD) begin m_phase = P_TRY; m_t = 0; m_run = 0; end
        end
        P_TRY: begin
          waiting = (m_run == 0);
          m_run   = ls ? m_run + 1 : 0;
          m_t++;
          if (m_run == LOCK_STABLE) begin
            m_phase = P_RUN; m_retries = 0;
          end else if (m_t >= LOCK_TIMEOUT && !(waiting && ls)) begin
            m_retries++;
            m_t = 0;
            m_phase = (m_retries == MAX_RETRIES) ? P_FAIL : P_HOLD;
          end
        end
        P_RUN:  if (!ls) begin m_phase = P_HOLD; m_t = 0; end
        P_BYP:  begin m_phase = P_HOLD; m_t = 0; m_retries = 0; end
        default: ;
      endcase
    end
    model_outputs();
  endtask

  // Advance one clock: model follows the edge, then wait for the falling edge
  // so the caller samples DUT outputs away from the active edge.
  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0; bypass_req = 1'b0; lock = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b1;
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; bypass_req = 1'b0; lock = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      lock       = 1'($urandom_range(0, 1));
      bypass_req = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (dut_out !== 7'b0) begin
        n_bad++;
        $display("FAIL reset_state cyc=%0d got=%b want=0000000", i, dut_out);
      end
    end
    bypass_req = 1'b0; lock = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_nominal();
    for (int e = 1; e <= 40; e++) begin
      lock = ((e - 1) >= 10);
      tick();
      n_checks++;
      if (dut_out !== exp_out) begin
        n_bad++; $display("FAIL nominal_model edge=%0d got=%b want=%b", e, dut_out, exp_out);
      end
      if (e == 3 || e == 4) begin
        n_checks++;
        if (pll_resetb !== (e == 4)) begin
          n_bad++; $display("FAIL nominal_resetb edge=%0d got=%b want=%b", e, pll_resetb, (e == 4));
        end
      end
      if (e == 27 || e == 28) begin
        n_checks++;
        if ({rst_out_n, locked} !== {2{e == 28}}) begin
          n_bad++; $display("FAIL nominal_release edge=%0d got=%b%b want=%0d", e, rst_out_n, locked, (e == 28));
        end
      end
      if (retry_count !== 2'd0) begin
        n_checks++; n_bad++;
        $display("FAIL nominal_retry edge=%0d got=%0d want=0", e, retry_count);
      end
    end
  endtask

  task automatic test_run_drop();
    for (int e = 1; e <= 40; e++) begin
      lock = ((e - 1) != 5);
      tick();
      n_checks++;
      if (dut_out !== exp_out) begin
        n_bad++; $display("FAIL drop_model edge=%0d got=%b want=%b", e, dut_out, exp_out);
      end
      if (e == 7) begin
        n_checks++;
        if ({locked, rst_out_n} !== 2'b11) begin
          n_bad++; $display("FAIL drop_early edge=%0d got=%b%b want=11", e, locked, rst_out_n);
        end
      end
      if (e == 8) begin
        n_checks++;
        if ({locked, rst_out_n, pll_resetb} !== 3'b000) begin
          n_bad++; $display("FAIL drop_release edge=%0d got=%b%b%b want=000", e, locked, rst_out_n, pll_resetb);
        end
      end
      if (e == 40) begin
        n_checks++;
        if ({locked, retry_count} !== 3'b100) begin
          n_bad++; $display("FAIL drop_relock got=%b%b want=100", locked, retry_count);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int            low_len = 0;
    int            pulses  = 0;
    bit            saw_rst = 1'b0;
    logic [RW-1:0] prev    = retry_count;
    int            steps[$];
    for (int e = 1; e <= 220; e++) begin
      lock = 1'b0;
      tick();
      n_checks++;
      if (dut_out !== exp_out) begin
        n_bad++; $display("FAIL timeout_model edge=%0d got=%b want=%b", e, dut_out, exp_out);
      end
      if (e >= 3 && rst_out_n !== 1'b0) saw_rst = 1'b1;
      if (pll_resetb === 1'b0) begin
        low_len++;
      end else begin
        if (low_len > 0) begin
          pulses++;
          n_checks++;
          if (low_len != RESET_HOLD) begin
            n_bad++; $display("FAIL timeout_pulse edge=%0d got=%0d want=%0d", e, low_len, RESET_HOLD);
          end
        end
        low_len = 0;
      end
      if (retry_count !== prev) begin
        steps.push_back(int'(retry_count));
        prev = retry_count;
      end
      if (e == 206 || e == 207) begin
        n_checks++;
        if (fail !== (e == 207)) begin
          n_bad++; $display("FAIL timeout_fail edge=%0d got=%b want=%b", e, fail, (e == 207));
        end
      end
    end
    n_checks++;
    if (steps.size() != 3 || steps[0] != 1 || steps[1] != 2 || steps[2] != 3) begin
      n_bad++; $display("FAIL timeout_steps got_n=%0d got=%p want=1,2,3", steps.size(), steps);
    end
    n_checks++;
    if (pulses != 3) begin
      n_bad++; $display("FAIL timeout_pulses got=%0d want=3", pulses);
    end
    n_checks++;
    if (saw_rst) begin
      n_bad++; $display("FAIL timeout_rst_out got=released want=held");
    end
  endtask

  task automatic test_bypass();
    for (int e = 1; e <= 50; e++) begin
      bypass_req = ((e - 1) < 20);
      lock       = ((e - 1) >= 20);
      tick();
      n_checks++;
      if (dut_out !== exp_out) begin
        n_bad++; $display("FAIL bypass_model edge=%0d got=%b want=%b", e, dut_out, exp_out);
      end
      if (e == 1) begin
        n_checks++;
        if ({pll_bypass, rst_out_n, fail, pll_resetb} !== 4'b1100) begin
          n_bad++; $display("FAIL bypass_enter got=%b%b%b%b want=1100", pll_bypass, rst_out_n, fail, pll_resetb);
        end
      end
      if (e == 21) begin
        n_checks++;
        if ({pll_bypass, rst_out_n, retry_count} !== 4'b0000) begin
          n_bad++; $display("FAIL bypass_exit got=%b%b%0d want=0,0,0", pll_bypass, rst_out_n, retry_count);
        end
      end
      if (e == 50) begin
        n_checks++;
        if (locked !== 1'b1) begin
          n_bad++; $display("FAIL bypass_relock got=%b want=1", locked);
        end
      end
    end
    bypass_req = 1'b0;
  endtask

  task automatic test_glitch();
    bit saw_rst = 1'b0;
    do_reset(2);
    for (int e = 1; e <= 110; e++) begin
      lock = ((e - 1) >= 4) && (((e - 1 - 4) % 12) < 8);
      tick();
      n_checks++;
      if (dut_out !== exp_out) begin
        n_bad++; $display("FAIL glitch_model edge=%0d got=%b want=%b", e, dut_out, exp_out);
      end
      if (rst_out_n !== 1'b0) saw_rst = 1'b1;
      if (e == 67 || e == 68) begin
        n_checks++;
        if (retry_count !== RW'(e == 68)) begin
          n_bad++; $display("FAIL glitch_timeout edge=%0d got=%0d want=%0d", e, retry_count, (e == 68));
        end
      end
    end
    n_checks++;
    if (saw_rst) begin
      n_bad++; $display("FAIL glitch_run got=reached want=never");
    end
  endtask

  task automatic test_reset_in_stable();
    do_reset(2);
    for (int e = 1; e <= 14; e++) begin
      lock = 1'b1;
      tick();
      n_checks++;
      if (dut_out !== exp_out) begin
        n_bad++; $display("FAIL rstmid_model edge=%0d got=%b want=%b", e, dut_out, exp_out);
      end
    end
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_out !== 7'b0) begin
      n_bad++; $display("FAIL rstmid_async got=%b want=0000000", dut_out);
    end
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      lock = 1'b1;
      tick();
      n_checks++;
      if (dut_out !== exp_out) begin
        n_bad++; $display("FAIL rstmid_resume edge=%0d got=%b want=%b", e, dut_out, exp_out);
      end
      if (e == 19 || e == 20) begin
        n_checks++;
        if (locked !== (e == 20)) begin
          n_bad++; $display("FAIL rstmid_lock edge=%0d got=%b want=%b", e, locked, (e == 20));
        end
      end
    end
  endtask

  task automatic test_random();
    int rst_hold = 0;
    int byp_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!reset) begin
        if (rst_hold == 0) reset = 1'b1;
        else rst_hold--;
      end else if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        model_reset();
        rst_hold = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 24) == 0) lock = ~lock;
      if (byp_left > 0) byp_left--;
      else if ($urandom_range(0, 299) == 0) byp_left = $urandom_range(1, 10);
      bypass_req = (byp_left > 0);
      tick();
      n_checks++;
      if (dut_out !== exp_out) begin
        n_bad++; $display("FAIL random_model cyc=%0d got=%b want=%b", i, dut_out, exp_out);
      end
    end
    reset = 1'b1; bypass_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_run_drop();
    test_timeout();
    test_bypass();
    test_glitch();
    test_reset_in_stable();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Control stage directly upstream of the iCE40 PLL primitive. It drives the PLL's RESETB and BYPASS pins and watches its LOCK output.
- Holds the downstream clock domain in reset until lock is proven stable. Retries the PLL on lock timeout and flags permanent failure.
- Runs entirely on the PLL reference clock (clk), never on the PLL output.

Parameters:
- RESET_HOLD, 4: clk cycles pll_resetb is held low on each (re)start; must be >=1.
- LOCK_STABLE, 16: consecutive synchronized-lock-high cycles required before release; must be >=1.
- LOCK_TIMEOUT, 64: clk cycles allowed in WAIT_LOCK before a retry; must be > LOCK_STABLE.
- MAX_RETRIES, 3: timeouts tolerated before FAIL; must be >=1.
- Counter width: $clog2(max(RESET_HOLD, LOCK_STABLE, LOCK_TIMEOUT)+1).
- RW: $clog2(MAX_RETRIES+1), derived.

Ports:
- clk, input, 1: reference clock; also feeds the PLL REFERENCECLK.
- reset, input, 1: asynchronous active-low reset (0 = reset).
- bypass_req, input, 1: synchronous request to bypass the PLL.
- lock, input, 1: PLL LOCK output, asynchronous to clk.
- pll_resetb, output, 1: to PLL RESETB (active-low).
- pll_bypass, output, 1: to PLL BYPASS.
- rst_out_n, output, 1: active-low reset for the downstream PLL clock domain.
- locked, output, 1: high only in RUN.
- fail, output, 1: high only in FAIL.
- retry_count, output, RW: number of timeouts since the last RUN or BYPASS exit.

Behaviour:
- Reset (reset=0):
  - State=HOLD, all counters=0, retry_count=0.
  - pll_resetb=0, pll_bypass=0, rst_out_n=0, locked=0, fail=0.
  - Sync flops cleared.
- Lock synchronizer: lock passes through a 2-flop synchronizer to produce lock_s. The FSM sees only lock_s, giving 2 cycles of latency.
- All outputs are registered, decoded from the next state. An output changes on the same edge as the state transition.
- HOLD:
  - pll_resetb=0, rst_out_n=0.
  - Counts RESET_HOLD cycles, then goes to WAIT_LOCK with pll_resetb=1 on that edge.
  - pll_resetb is low for exactly RESET_HOLD cycles.
- WAIT_LOCK:
  - The timeout counter increments each cycle.
  - lock_s=1 goes to STABLE, with the stable counter set to 1.
  - If the counter reaches LOCK_TIMEOUT with lock_s=0, retry_count increments. If the new value equals MAX_RETRIES, go to FAIL; otherwise go to HOLD.
- STABLE:
  - The stable counter increments while lock_s=1.
  - When the counter reaches LOCK_STABLE, go to RUN.
  - If lock_s=0, go to WAIT_LOCK. The timeout counter is NOT cleared, so glitchy lock still times out.
- RUN:
  - rst_out_n=1, locked=1; retry_count clears to 0 on entry.
  - If lock_s=0, go to HOLD. On that edge rst_out_n=0, locked=0 and pll_resetb=0. No retry is counted.
- FAIL:
  - fail=1, pll_resetb=0, rst_out_n=0.
  - The block stays in FAIL until reset or bypass_req.
- BYPASS:
  - Entered from any state, including FAIL, when bypass_req=1. bypass_req has priority over every other transition in the same cycle.
  - Outputs: pll_bypass=1, pll_resetb=0, rst_out_n=1, locked=0, fail=0.
  - On bypass_req=0, go to HOLD with retry_count=0 and counters cleared.
- Counters saturate; they never wrap. The retry_count maximum is MAX_RETRIES.
- Asserting reset mid-sequence from any state immediately forces the reset values. The rising edge of lock during reset is ignored.

Test Plan:
- Defaults, reset released at cycle 0, lock rises at cycle 10 and stays high:
  - pll_resetb rises at edge 4.
  - rst_out_n and locked rise at edge 10+2+16=28.
  - retry_count=0 throughout.
- lock held at 0:
  - Three timeouts occur, with retry_count stepping 1, 2, 3.
  - fail=1 after the third timeout.
  - pll_resetb pulses low for 4 cycles between attempts.
  - rst_out_n stays 0 throughout.
- Glitchy lock, toggling high 8 / low 4 cycles from WAIT_LOCK entry:
  - STABLE never completes, so RUN is never reached.
  - A timeout occurs 64 cycles after WAIT_LOCK entry, with retry_count=1.
- In RUN, drop lock for 1 cycle:
  - Exactly 2 cycles later rst_out_n=0, locked=0 and pll_resetb=0.
  - The full resequence completes with retry_count=0.
- From FAIL, assert bypass_req for 20 cycles:
  - Next edge: pll_bypass=1, rst_out_n=1, fail=0.
  - After deassert: HOLD, retry_count=0, and a normal lock sequence succeeds.
- Assert reset in STABLE at stable count 10, hold 3 cycles, release:
  - All outputs return to reset values immediately.
  - The sequence restarts from HOLD.
  - The earlier stable count does not carry over: 16 new cycles are needed.
